clock_update_ctrl: RTL

//  Sequences all writes to the sec/min/hour time counters of the digital clock.
//  - Shares the counter datapath between the 1 Hz timekeeping tick and the setting-mode

---
 rtl/clock_pkg.sv | 34 +++
 rtl/clock_prescaler.sv | 52 +++++
 rtl/clock_update_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock update controller.
//   upd_state_e  : one-hot encodings of the update FSM states
//   REQ_*        : bit positions of the pending-request flags
//   pick_request : one-hot grant of the highest-priority pending request
//                  (sclr > tck > hinc > minc)
package clock_pkg;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_SEC_CLR  = 5'b00010,
        ST_SEC_UPD  = 5'b00100,
        ST_MIN_UPD  = 5'b01000,
        ST_HOUR_UPD = 5'b10000
    } upd_state_e;

    localparam int NUM_REQ  = 4;
    localparam int REQ_TCK  = 0;
    localparam int REQ_SCLR = 1;
    localparam int REQ_HINC = 2;
    localparam int REQ_MINC = 3;

    typedef logic [NUM_REQ-1:0] req_vec_t;

    function automatic req_vec_t pick_request(input req_vec_t pend);
        req_vec_t grant;
        grant = '0;
        if (pend[REQ_SCLR])      grant[REQ_SCLR] = 1'b1;
        else if (pend[REQ_TCK])  grant[REQ_TCK]  = 1'b1;
        else if (pend[REQ_HINC]) grant[REQ_HINC] = 1'b1;
        else if (pend[REQ_MINC]) grant[REQ_MINC] = 1'b1;
        return grant;
    endfunction

endpackage

// File: rtl/clock_prescaler.sv
// 1 Hz tick prescaler and display blink divider.
// Ports:
//   ck, sysreset_n : clock, synchronous active-low reset
//   run            : 1 = count; 0 = hold the tick counter at 0
//   tick           : high for the last cycle of each CLK_HZ-cycle second
//   blink          : square wave toggling every BLINK_DIV cycles, resets to 1
module clock_prescaler #(
    parameter int CLK_HZ    = 1000,
    parameter int BLINK_DIV = 500
) (
    input  logic ck,
    input  logic sysreset_n,
    input  logic run,
    output logic tick,
    output logic blink
);

    localparam int TW = $clog2(CLK_HZ + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic [BW-1:0] blink_cnt;

    assign tick = run && (tick_cnt == TICK_LAST);

    always_ff @(posedge ck) begin
        if (!sysreset_n) begin
            tick_cnt <= '0;
        end else if (!run) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (!sysreset_n) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_update_ctrl.sv
// Sequences all writes to the sec/min/hour counters: arbitrates between the
// 1 Hz tick and the setting commands, issues one-cycle enable pulses and
// ripples carries one stage per cycle.
// Optional feature macro: CLOCK_SEC_ROUND_EN (seconds clear rounds up a minute
// when sec_ge30 is set; otherwise sec_ge30 is ignored).
// Ports:
//   ck, sysreset_n                : clock, synchronous active-low reset
//   run                           : 1 = timekeeping, 0 = setting mode
//   sec_reset, min_inc, hour_inc  : level commands, acted on at rising edge
//   sec_is59, min_is59, sec_ge30  : counter status
//   sec_clr, sec_en, min_en, hour_en : one-cycle counter pulses
//   blink                         : display blink square wave
//   busy                          : FSM not in IDLE
//
// state    | meaning
// IDLE     | waiting; grants the highest-priority pending request
// SEC_CLR  | clear seconds (optionally round up into MIN_UPD)
// SEC_UPD  | increment seconds; carry into minutes at 59
// MIN_UPD  | increment minutes; carry into hours only on a tick ripple
// HOUR_UPD | increment hours
module clock_update_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ    = 1000,
    parameter int BLINK_DIV = 500
) (
    input  logic ck,
    input  logic sysreset_n,
    input  logic run,
    input  logic sec_reset,
    input  logic min_inc,
    input  logic hour_inc,
    input  logic sec_is59,
    input  logic min_is59,
    input  logic sec_ge30,
    output logic sec_clr,
    output logic sec_en,
    output logic min_en,
    output logic hour_en,
    output logic blink,
    output logic busy
);

    logic       tick;
    logic [2:0] cmd_q;
    logic [2:0] cmd_prev;
    logic [2:0] cmd_rise;
    req_vec_t   req_set;
    req_vec_t   pend;
    req_vec_t   grant;
    upd_state_e state, state_nx;
    logic       carry, carry_nx;

`ifndef CLOCK_SEC_ROUND_EN
    logic unused_sec_ge30;
    assign unused_sec_ge30 = sec_ge30;
`endif

    clock_prescaler #(
        .CLK_HZ    (CLK_HZ),
        .BLINK_DIV (BLINK_DIV)
    ) u_prescaler (
        .ck         (ck),
        .sysreset_n (sysreset_n),
        .run        (run),
        .tick       (tick),
        .blink      (blink)
    );

    // Both edge-detect stages reset high so a command held through reset
    // is not seen as a new request.
    always_ff @(posedge ck) begin
        if (!sysreset_n) begin
            cmd_q    <= 3'b111;
            cmd_prev <= 3'b111;
        end else begin
            cmd_q    <= {hour_inc, min_inc, sec_reset};
            cmd_prev <= cmd_q;
        end
    end

    assign cmd_rise = cmd_q & ~cmd_prev;

    always_comb begin
        req_set           = '0;
        req_set[REQ_TCK]  = tick;
        req_set[REQ_SCLR] = cmd_rise[0];
        req_set[REQ_MINC] = cmd_rise[1];
        req_set[REQ_HINC] = cmd_rise[2];
    end

    assign grant = (state == ST_IDLE) ? pick_request(pend) : '0;

    // Set after clear: a request arriving as its flag is served stays pending.
    always_ff @(posedge ck) begin
        if (!sysreset_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~grant) | req_set;
        end
    end

    always_ff @(posedge ck) begin
        if (!sysreset_n) begin
            state <= ST_IDLE;
            carry <= 1'b0;
        end else begin
            state <= state_nx;
            carry <= carry_nx;
        end
    end

    always_comb begin
        state_nx = state;
        carry_nx = carry;
        case (state)
            ST_IDLE: begin
                if (grant[REQ_SCLR]) begin
                    state_nx = ST_SEC_CLR;
                end else if (grant[REQ_TCK]) begin
                    state_nx = ST_SEC_UPD;
                end else if (grant[REQ_HINC]) begin
                    state_nx = ST_HOUR_UPD;
                end else if (grant[REQ_MINC]) begin
                    state_nx = ST_MIN_UPD;
                    carry_nx = 1'b0;
                end
            end
            ST_SEC_CLR: begin
`ifdef CLOCK_SEC_ROUND_EN
                if (sec_ge30) begin
                    state_nx = ST_MIN_UPD;
                    carry_nx = 1'b0;
                end else begin
                    state_nx = ST_IDLE;
                end
`else
                state_nx = ST_IDLE;
`endif
            end
            ST_SEC_UPD: begin
                // sec_is59 is the pre-increment value of this cycle
                if (sec_is59) begin
                    state_nx = ST_MIN_UPD;
                    carry_nx = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_MIN_UPD: begin
                state_nx = (carry && min_is59) ? ST_HOUR_UPD : ST_IDLE;
            end
            ST_HOUR_UPD: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                carry_nx = 1'b0;
            end
        endcase
    end

    always_comb begin
        sec_clr = (state == ST_SEC_CLR);
        sec_en  = (state == ST_SEC_UPD);
        min_en  = (state == ST_MIN_UPD);
        hour_en = (state == ST_HOUR_UPD);
        busy    = (state != ST_IDLE);
    end

endmodule
